traffic_light_monitor: RTL and testbench

//  Passive safety monitor on the far end of the traffic_light lamp interface: samples NS_G/NS_Y/EW_G/EW_Y

---
 rtl/traffic_light_monitor_pkg.sv | 53 +++++
 rtl/traffic_light_monitor_if.sv | 28 ++
 rtl/traffic_phase_decode.sv | 26 ++
 rtl/traffic_light_monitor.sv | 149 ++++++++++++++
 tb/tb_traffic_light_monitor.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/traffic_light_monitor_pkg.sv
// Shared phase and fault encodings for the traffic light lamp monitor,
// plus small helpers for classifying phases and checking sequencing.
package traffic_light_monitor_pkg;

  typedef enum logic [2:0] {
    PH_ALL_RED = 3'd0,
    PH_NSG     = 3'd1,
    PH_NSY     = 3'd2,
    PH_EWG     = 3'd3,
    PH_EWY     = 3'd4,
    PH_INVALID = 3'd7
  } phase_e;

  typedef enum logic [2:0] {
    FC_NONE        = 3'd0,
    FC_CONFLICT    = 3'd1,
    FC_ILLEGAL_SEQ = 3'd2,
    FC_SHORT_GREEN = 3'd3,
    FC_YELLOW_TIME = 3'd4,
    FC_STUCK       = 3'd5
  } fault_e;

  localparam int COUNT_W = 8;

  function automatic logic is_green(input phase_e ph);
    return (ph == PH_NSG) || (ph == PH_EWG);
  endfunction

  function automatic logic is_yellow(input phase_e ph);
    return (ph == PH_NSY) || (ph == PH_EWY);
  endfunction

  // Normal rotation NSG->NSY->EWG->EWY->NSG; anything may drop to ALL_RED;
  // ALL_RED may only restart on a green.
  function automatic logic legal_step(input phase_e from_ph, input phase_e to_ph);
    logic ok;
    ok = 1'b0;
    if (to_ph == PH_ALL_RED) begin
      ok = 1'b1;
    end else begin
      case (from_ph)
        PH_NSG:     ok = (to_ph == PH_NSY);
        PH_NSY:     ok = (to_ph == PH_EWG);
        PH_EWG:     ok = (to_ph == PH_EWY);
        PH_EWY:     ok = (to_ph == PH_NSG);
        PH_ALL_RED: ok = (to_ph == PH_NSG) || (to_ph == PH_EWG);
        default:    ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Lamp-side observation bus and fault reporting bus of the monitor.
// master = the environment (controller lamps + supervisor), slave = monitor.
interface traffic_light_monitor_if;
  import traffic_light_monitor_pkg::*;

  logic               tick;
  logic               emergency;
  logic               NS_G;
  logic               NS_Y;
  logic               EW_G;
  logic               EW_Y;
  logic               clear;
  logic [2:0]         phase;
  logic               fault;
  logic [2:0]         fault_code;
  logic [COUNT_W-1:0] fault_count;

  modport master (
    output tick, emergency, NS_G, NS_Y, EW_G, EW_Y, clear,
    input  phase, fault, fault_code, fault_count
  );

  modport slave (
    input  tick, emergency, NS_G, NS_Y, EW_G, EW_Y, clear,
    output phase, fault, fault_code, fault_count
  );

endinterface

// File: rtl/traffic_phase_decode.sv
// Pure combinational decode of the four lamp drives into a phase code.
// Exactly one lamp lit (or none) is a valid phase; anything else is INVALID.
module traffic_phase_decode
  import traffic_light_monitor_pkg::*;
(
  input  logic   ns_g,
  input  logic   ns_y,
  input  logic   ew_g,
  input  logic   ew_y,
  output phase_e phase
);

  // Map the one-hot lamp pattern to a phase
  always_comb begin
    phase = PH_INVALID;
    case ({ns_g, ns_y, ew_g, ew_y})
      4'b0000: phase = PH_ALL_RED;
      4'b1000: phase = PH_NSG;
      4'b0100: phase = PH_NSY;
      4'b0010: phase = PH_EWG;
      4'b0001: phase = PH_EWY;
      default: phase = PH_INVALID;
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive safety monitor for the traffic light lamp outputs. Tracks the
// current phase, times it in ticks and raises sticky faults for lamp
// conflicts, illegal sequencing, short/long phases and stuck phases.
module traffic_light_monitor
  import traffic_light_monitor_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int MIN_GREEN  = 5,
  parameter int MIN_YELLOW = 2,
  parameter int MAX_YELLOW = 3,
  parameter int MAX_PHASE  = 12
) (
  input logic                   clk,
  input logic                   reset,
  traffic_light_monitor_if.slave mon
);

  localparam logic [CNT_W-1:0]   CNT_MAX      = '1;
  localparam logic [CNT_W-1:0]   MIN_GREEN_C  = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0]   MIN_YELLOW_C = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0]   MAX_YELLOW_C = CNT_W'(MAX_YELLOW);
  localparam logic [CNT_W-1:0]   MAX_PHASE_C  = CNT_W'(MAX_PHASE);
  localparam logic [COUNT_W-1:0] COUNT_MAX    = '1;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [COUNT_W-1:0] sat_inc_count(input logic [COUNT_W-1:0] v);
    return (v == COUNT_MAX) ? v : v + 1'b1;
  endfunction

  // ---- stage p0: combinational decode of the current lamp sample ----
  phase_e phase_p0;

  traffic_phase_decode u_decode (
    .ns_g  (mon.NS_G),
    .ns_y  (mon.NS_Y),
    .ew_g  (mon.EW_G),
    .ew_y  (mon.EW_Y),
    .phase (phase_p0)
  );

  // ---- stage p1: tracker, timer and fault state ----
  phase_e               phase_p1;
  phase_e               prev_p1;
  logic                 armed_p1;
  logic [CNT_W-1:0]     tick_cnt_p1;
  logic                 stuck_fired_p1;
  logic                 fault_p1;
  logic [2:0]           fault_code_p1;
  logic [COUNT_W-1:0]   fault_count_p1;

  logic                 change;
  logic                 conflict;
  logic                 illegal_seq;
  logic                 short_green;
  logic                 yellow_time;
  logic                 stuck;
  logic [CNT_W-1:0]     cnt_nxt;
  logic                 any_fault;
  fault_e               new_code;

  // Classify the current sample against the tracked phase and its timer
  always_comb begin
    change      = 1'b0;
    conflict    = 1'b0;
    illegal_seq = 1'b0;
    short_green = 1'b0;
    yellow_time = 1'b0;
    stuck       = 1'b0;
    cnt_nxt     = '0;
    if (phase_p0 == PH_INVALID) begin
      conflict = 1'b1;
    end else if (armed_p1) begin
      if (phase_p0 != prev_p1) begin
        change      = 1'b1;
        illegal_seq = !legal_step(prev_p1, phase_p0);
        // Dropping to ALL_RED is an emergency preempt: no timing checks
        if (phase_p0 != PH_ALL_RED) begin
          short_green = is_green(prev_p1) && (tick_cnt_p1 < MIN_GREEN_C);
          yellow_time = is_yellow(prev_p1) &&
                        ((tick_cnt_p1 < MIN_YELLOW_C) || (tick_cnt_p1 > MAX_YELLOW_C));
        end
      end else begin
        cnt_nxt = mon.tick ? sat_inc_cnt(tick_cnt_p1) : tick_cnt_p1;
        stuck   = (prev_p1 != PH_ALL_RED) && !mon.emergency && !stuck_fired_p1 &&
                  (cnt_nxt >= MAX_PHASE_C);
      end
    end
  end

  // Merge simultaneous violations into one event, highest priority code wins
  always_comb begin
    any_fault = conflict | illegal_seq | short_green | yellow_time | stuck;
    new_code  = FC_NONE;
    if (conflict)         new_code = FC_CONFLICT;
    else if (illegal_seq) new_code = FC_ILLEGAL_SEQ;
    else if (short_green) new_code = FC_SHORT_GREEN;
    else if (yellow_time) new_code = FC_YELLOW_TIME;
    else if (stuck)       new_code = FC_STUCK;
  end

  // Phase tracker, arming and per-phase tick timer
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_p1       <= PH_INVALID;
      prev_p1        <= PH_ALL_RED;
      armed_p1       <= 1'b0;
      tick_cnt_p1    <= '0;
      stuck_fired_p1 <= 1'b0;
    end else begin
      phase_p1    <= phase_p0;
      tick_cnt_p1 <= cnt_nxt;
      if (phase_p0 == PH_INVALID) begin
        armed_p1       <= 1'b0;
        stuck_fired_p1 <= 1'b0;
      end else begin
        armed_p1 <= 1'b1;
        prev_p1  <= phase_p0;
        if (!armed_p1 || change) stuck_fired_p1 <= 1'b0;
        else if (stuck)          stuck_fired_p1 <= 1'b1;
      end
    end
  end

  // Sticky fault flag, first-fault code and saturating event counter
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_p1       <= 1'b0;
      fault_code_p1  <= FC_NONE;
      fault_count_p1 <= '0;
    end else if (any_fault) begin
      fault_p1       <= 1'b1;
      fault_count_p1 <= sat_inc_count(fault_count_p1);
      // A clear in the same cycle makes this fault the new "first" one
      if (!fault_p1 || mon.clear) fault_code_p1 <= new_code;
    end else if (mon.clear) begin
      fault_p1      <= 1'b0;
      fault_code_p1 <= FC_NONE;
    end
  end

  assign mon.phase       = phase_p1;
  assign mon.fault       = fault_p1;
  assign mon.fault_code  = fault_code_p1;
  assign mon.fault_count = fault_count_p1;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: lamp patterns are driven just
// after each rising edge and outputs are checked 1 time unit after the edge
// that sampled them.
module tb_traffic_light_monitor;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  traffic_light_monitor_if bus ();

  traffic_light_monitor dut (
    .clk   (clk),
    .reset (reset),
    .mon   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, landing 1 unit after the last one
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive lamps for a phase code; 7 lights both greens
  task automatic drive(input int ph);
    bus.NS_G = 1'b0;
    bus.NS_Y = 1'b0;
    bus.EW_G = 1'b0;
    bus.EW_Y = 1'b0;
    case (ph)
      1: bus.NS_G = 1'b1;
      2: bus.NS_Y = 1'b1;
      3: bus.EW_G = 1'b1;
      4: bus.EW_Y = 1'b1;
      7: begin bus.NS_G = 1'b1; bus.EW_G = 1'b1; end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.clear     = 1'b0;
    bus.emergency = 1'b0;
    bus.tick      = 1'b1;
    drive(0);
    cyc(2);
    reset = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    // Reset state, then first legal sample arms without faulting
    do_reset();
    check("rst_phase", 32'(bus.phase), 7);
    check("rst_fault", 32'(bus.fault), 0);
    check("rst_code", 32'(bus.fault_code), 0);
    check("rst_count", 32'(bus.fault_count), 0);

    // Full legal rotation with in-range timings
    drive(1); cyc(1);
    check("seq_nsg", 32'(bus.phase), 1);
    check("seq_nsg_fault", 32'(bus.fault), 0);
    cyc(5);
    drive(2); cyc(1);
    check("seq_nsy", 32'(bus.phase), 2);
    cyc(2);
    drive(3); cyc(1);
    check("seq_ewg", 32'(bus.phase), 3);
    cyc(5);
    drive(4); cyc(1);
    check("seq_ewy", 32'(bus.phase), 4);
    cyc(3);
    drive(1); cyc(1);
    check("seq_nsg2", 32'(bus.phase), 1);
    check("seq_fault", 32'(bus.fault), 0);
    check("seq_count", 32'(bus.fault_count), 0);
    // Early exit to ALL_RED skips timing; ALL_RED -> EWG is legal
    cyc(1);
    drive(0); cyc(1);
    check("pre_allred", 32'(bus.phase), 0);
    drive(3); cyc(1);
    check("pre_ewg", 32'(bus.phase), 3);
    check("pre_count", 32'(bus.fault_count), 0);

    // Lamp conflict, then re-arm on a legal sample without further faults
    drive(7); cyc(1);
    check("conf_phase", 32'(bus.phase), 7);
    check("conf_fault", 32'(bus.fault), 1);
    check("conf_code", 32'(bus.fault_code), 1);
    check("conf_count", 32'(bus.fault_count), 1);
    drive(1); cyc(1);
    check("rearm_phase", 32'(bus.phase), 1);
    cyc(3);
    check("rearm_count", 32'(bus.fault_count), 1);

    // Short green, clear, then overlong yellow
    do_reset();
    drive(1); cyc(1);
    cyc(3);
    drive(2); cyc(1);
    check("short_code", 32'(bus.fault_code), 3);
    check("short_count", 32'(bus.fault_count), 1);
    bus.clear = 1'b1; cyc(1); bus.clear = 1'b0;
    check("clr_fault", 32'(bus.fault), 0);
    check("clr_code", 32'(bus.fault_code), 0);
    check("clr_count", 32'(bus.fault_count), 1);
    cyc(4);
    drive(3); cyc(1);
    check("ylong_fault", 32'(bus.fault), 1);
    check("ylong_code", 32'(bus.fault_code), 4);
    check("ylong_count", 32'(bus.fault_count), 2);

    // Tick gating: no ticks means the green never accumulates time
    do_reset();
    drive(1); cyc(1);
    bus.tick = 1'b0; cyc(10); bus.tick = 1'b1;
    drive(2); cyc(1);
    check("notick_code", 32'(bus.fault_code), 3);

    // Watchdog fires once when the timer reaches MAX_PHASE
    do_reset();
    drive(1); cyc(1);
    cyc(11);
    check("wd_before", 32'(bus.fault), 0);
    cyc(1);
    check("wd_fault", 32'(bus.fault), 1);
    check("wd_code", 32'(bus.fault_code), 5);
    check("wd_count", 32'(bus.fault_count), 1);
    cyc(8);
    check("wd_once", 32'(bus.fault_count), 1);
    // Emergency ALL_RED held long never faults
    bus.emergency = 1'b1;
    drive(0); cyc(1);
    check("emg_phase", 32'(bus.phase), 0);
    cyc(30);
    check("emg_count", 32'(bus.fault_count), 1);

    // Illegal ALL_RED -> EWY with clear in the same cycle
    bus.clear = 1'b1;
    drive(4); cyc(1);
    bus.clear = 1'b0;
    check("ill_fault", 32'(bus.fault), 1);
    check("ill_code", 32'(bus.fault_code), 2);
    check("ill_count", 32'(bus.fault_count), 2);
    bus.emergency = 1'b0; cyc(2);
    check("emg_drop_count", 32'(bus.fault_count), 2);

    // 300 conflict samples saturate the counter; first code is kept
    drive(7); cyc(300);
    check("sat_count", 32'(bus.fault_count), 255);
    check("sat_code", 32'(bus.fault_code), 2);
    // Clear leaves the counter alone
    bus.clear = 1'b1;
    drive(0); cyc(1);
    bus.clear = 1'b0;
    check("sat_clr_fault", 32'(bus.fault), 0);
    check("sat_clr_code", 32'(bus.fault_code), 0);
    check("sat_clr_count", 32'(bus.fault_count), 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
